// File: rtl/text_overlay.sv
// Text overlay renderer: a writable string buffer of glyph codes with blink bits,
// drawn through a fixed 3-stage pixel pipeline with runtime origin and 2^n scale.
module text_overlay #(
  parameter int MAX_CHARS    = 16,
  parameter int HCOUNT_W     = 11,
  parameter int VCOUNT_W     = 10,
  parameter int MAX_SHIFT    = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         char_we,
  input  logic [$clog2(MAX_CHARS)-1:0] char_addr,
  input  logic [7:0]                   char_code,
  input  logic                         char_blink,
  input  logic [HCOUNT_W-1:0]          origin_x,
  input  logic [VCOUNT_W-1:0]          origin_y,
  input  logic [1:0]                   scale_shift,
  input  logic [HCOUNT_W-1:0]          hcount_in,
  input  logic [VCOUNT_W-1:0]          vcount_in,
  input  logic                         valid_in,
  output logic                         pixel_out,
  output logic                         valid_out,
  output logic                         busy_out
);

  localparam int IDX_W = $clog2(MAX_CHARS);
  localparam int DXW   = HCOUNT_W + 1;
  localparam int DYW   = VCOUNT_W + 1;
  localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(MAX_CHARS - 1);
  localparam logic [IDX_W:0]   SLOT_COUNT = (IDX_W + 1)'(MAX_CHARS);
  localparam logic [1:0]       SHIFT_MAX  = (MAX_SHIFT > 3) ? 2'd3 : 2'(MAX_SHIFT);
  localparam logic [31:0]      BOX_COLS   = 32'(MAX_CHARS * 8);
  localparam logic [31:0]      BOX_ROWS   = 32'd8;
  localparam logic [7:0]       CODE_SPACE = 8'd10;

  // Rows top to bottom, 5 bits each, MSB = leftmost pixel; row 7 is the descender gap.
  localparam logic [39:0] GLYPH_H = 40'b10001_10001_10001_11111_10001_10001_10001_00000;
  localparam logic [39:0] GLYPH_E = 40'b11111_10000_10000_11110_10000_10000_11111_00000;
  localparam logic [39:0] GLYPH_A = 40'b01110_10001_10001_11111_10001_10001_10001_00000;
  localparam logic [39:0] GLYPH_R = 40'b11110_10001_10001_11110_10100_10010_10001_00000;
  localparam logic [39:0] GLYPH_T = 40'b11111_00100_00100_00100_00100_00100_00100_00000;
  localparam logic [39:0] GLYPH_S = 40'b01111_10000_10000_01110_00001_00001_11110_00000;
  localparam logic [39:0] GLYPH_N = 40'b10001_11001_10101_10011_10001_10001_10001_00000;
  localparam logic [39:0] GLYPH_O = 40'b01110_10001_10001_10001_10001_10001_01110_00000;
  localparam logic [39:0] GLYPH_C = 40'b01110_10001_10000_10000_10000_10001_01110_00000;
  localparam logic [39:0] GLYPH_M = 40'b10001_11011_10101_10101_10001_10001_10001_00000;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [7:0] code_mem_q  [MAX_CHARS];
  logic [7:0] code_mem_d  [MAX_CHARS];
  logic       blink_mem_q [MAX_CHARS];
  logic       blink_mem_d [MAX_CHARS];

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;

  logic             v1_q, v1_d, in_box1_q, in_box1_d;
  logic [IDX_W-1:0] idx1_q, idx1_d;
  logic [2:0]       col1_q, col1_d, row1_q, row1_d;

  logic       v2_q, v2_d, in_box2_q, in_box2_d, blink2_q, blink2_d;
  logic [2:0] col2_q, col2_d, row2_q, row2_d;
  logic [7:0] code2_q, code2_d;

  logic v3_q, v3_d, pix3_q, pix3_d;

  logic           wr_ok, tick;
  logic [1:0]     eff_shift;
  logic [DXW-1:0] hx, ox, dx, ux;
  logic [DYW-1:0] vy, oy, dy, uy;

  function automatic logic glyph_bit(input logic [7:0] code, input logic [2:0] row,
                                     input logic [2:0] col);
    logic [39:0] g;
    logic [5:0]  base;
    logic [4:0]  r;
    case (code)
      8'd0:    g = GLYPH_H;
      8'd1:    g = GLYPH_E;
      8'd2:    g = GLYPH_A;
      8'd3:    g = GLYPH_R;
      8'd4:    g = GLYPH_T;
      8'd5:    g = GLYPH_S;
      8'd6:    g = GLYPH_N;
      8'd7:    g = GLYPH_O;
      8'd8:    g = GLYPH_C;
      8'd9:    g = GLYPH_M;
      default: g = '0;
    endcase
    base = 6'd35 - 6'd5 * {3'b000, row};
    r = g[base +: 5];
    glyph_bit = (col <= 3'd4) ? r[3'd4 - col] : 1'b0;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == PTR_LAST) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  assign wr_ok = (state_q == ST_RUN) && char_we && ({1'b0, char_addr} < SLOT_COUNT);

  // The clear sweep owns the write port; host writes are only taken in RUN.
  always_comb begin
    code_mem_d  = code_mem_q;
    blink_mem_d = blink_mem_q;
    if (state_q == ST_CLEAR) begin
      code_mem_d[clr_ptr_q]  = CODE_SPACE;
      blink_mem_d[clr_ptr_q] = 1'b0;
    end else if (wr_ok) begin
      code_mem_d[char_addr]  = char_code;
      blink_mem_d[char_addr] = char_blink;
    end
  end

  assign tick = valid_in && (hcount_in == '0) && (vcount_in == '0) && (state_q == ST_RUN);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Geometry works one bit wider than the counters so pixels left/above the box never wrap in.
  always_comb begin
    eff_shift = (scale_shift > SHIFT_MAX) ? SHIFT_MAX : scale_shift;
    hx        = {1'b0, hcount_in};
    ox        = {1'b0, origin_x};
    vy        = {1'b0, vcount_in};
    oy        = {1'b0, origin_y};
    dx        = hx - ox;
    dy        = vy - oy;
    ux        = dx >> eff_shift;
    uy        = dy >> eff_shift;
    v1_d      = valid_in;
    in_box1_d = (hx >= ox) && (vy >= oy) && (32'(ux) < BOX_COLS) && (32'(uy) < BOX_ROWS);
    idx1_d    = IDX_W'(ux >> 3);
    col1_d    = ux[2:0];
    row1_d    = uy[2:0];
  end

  always_comb begin
    v2_d      = v1_q;
    in_box2_d = in_box1_q;
    col2_d    = col1_q;
    row2_d    = row1_q;
    code2_d   = code_mem_q[idx1_q];
    blink2_d  = blink_mem_q[idx1_q];
  end

  always_comb begin
    v3_d   = v2_q;
    pix3_d = v2_q && in_box2_q && glyph_bit(code2_q, row2_q, col2_q) &&
             !(blink2_q && phase_q) && (state_q == ST_RUN);
  end

  always_ff @(posedge clk_in) begin
    code_mem_q  <= code_mem_d;
    blink_mem_q <= blink_mem_d;
    idx1_q      <= idx1_d;
    col1_q      <= col1_d;
    row1_q      <= row1_d;
    col2_q      <= col2_d;
    row2_q      <= row2_d;
    code2_q     <= code2_d;
    blink2_q    <= blink2_d;
    if (!rst_in) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      v1_q        <= 1'b0;
      in_box1_q   <= 1'b0;
      v2_q        <= 1'b0;
      in_box2_q   <= 1'b0;
      v3_q        <= 1'b0;
      pix3_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      v1_q        <= v1_d;
      in_box1_q   <= in_box1_d;
      v2_q        <= v2_d;
      in_box2_q   <= in_box2_d;
      v3_q        <= v3_d;
      pix3_q      <= pix3_d;
    end
  end

  assign pixel_out = pix3_q;
  assign valid_out = v3_q;
  assign busy_out  = (state_q == ST_CLEAR);

endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Parametrised, pipelined text renderer for the video path.
- Holds a writable string buffer of glyph codes with a per-character blink attribute.
- Maps each incoming (hcount, vcount) pixel to a glyph bit from an internal 8x5 font, with runtime origin and power-of-two scale.
- Sits between the pixel counters and the compositing mux; it replaces fixed one-word letter lookups.

Parameters:
- MAX_CHARS, 16: string buffer depth; must be a power of two, at least 2.
- HCOUNT_W, 11: width of hcount_in and origin_x.
- VCOUNT_W, 10: width of vcount_in and origin_y.
- MAX_SHIFT, 2: largest accepted scale_shift; scale = 1 << scale_shift.
- BLINK_FRAMES, 30: frames per blink half-period; must be at least 1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, active-low, synchronous.
- char_we  input  1  write strobe for the string buffer.
- char_addr  input  $clog2(MAX_CHARS)  buffer slot to write.
- char_code  input  8  glyph code: 0..10 = H,E,A,R,T,S,N,O,C,M,space; 11..255 render blank.
- char_blink  input  1  blink attribute stored with the code.
- origin_x  input  HCOUNT_W  left edge of the text box.
- origin_y  input  VCOUNT_W  top edge of the text box.
- scale_shift  input  2  scale exponent; values above MAX_SHIFT clamp to MAX_SHIFT.
- hcount_in  input  HCOUNT_W  pixel x.
- vcount_in  input  VCOUNT_W  pixel y.
- valid_in  input  1  pixel coordinate valid.
- pixel_out  output  1  text pixel is lit.
- valid_out  output  1  valid_in delayed 3 cycles.
- busy_out  output  1  buffer clear in progress.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - pixel_out=0, valid_out=0, pipeline valids cleared.
  - Frame counter=0, blink phase=0.
  - FSM enters CLEAR with clear pointer 0; busy_out=1 from the first edge after reset.
- FSM states:
  - CLEAR: each cycle writes {code=10, blink=0} to slot ptr, then ptr++. After slot MAX_CHARS-1 is written, go to RUN; busy_out=0 on that transition. CLEAR lasts exactly MAX_CHARS cycles after rst_in deasserts.
  - RUN: normal operation.
  - Reasserting rst_in during CLEAR or RUN restarts CLEAR from slot 0.
- Writes:
  - Accepted only in RUN with char_we=1 and char_addr<MAX_CHARS; all others are dropped silently.
  - Buffer read is read-first: a same-cycle write to the slot being rendered shows the old code; the new code is visible from the next read.
- Geometry:
  - s = effective shift; dx = hcount_in - origin_x; dy = vcount_in - origin_y.
  - in_box = (hcount_in >= origin_x) AND (vcount_in >= origin_y) AND (dx >> s) < MAX_CHARS*8 AND (dy >> s) < 8.
  - Compare in widths one bit wider than the operands; no wrap-around.
  - ux = dx >> s; idx = ux >> 3; col = ux[2:0]; row = (dy >> s)[2:0].
- Glyph lookup:
  - Each cell is 8 columns wide. Glyph columns 0..4 are lit from row bit [4-col], so the MSB is the leftmost pixel. Columns 5..7 are always the gap (0).
  - Row 0 is the top row.
- Pipeline, fixed latency 3, no stalls, one pixel per cycle:
  - S1 registers in_box, idx, col, row.
  - S2 reads the buffer at idx.
  - S3 looks up the glyph and applies blink.
  - pixel_out = valid3 AND in_box3 AND glyph_bit AND NOT(blink3 AND phase) AND (state==RUN).
- Blink:
  - A frame tick occurs when valid_in=1, hcount_in=0 and vcount_in=0.
  - On each tick, the counter increments. When it was BLINK_FRAMES-1, it wraps to 0 and the phase toggles.
  - Ticks during CLEAR are ignored.
- valid_out tracks valid_in during CLEAR too; pixel_out is held 0 throughout CLEAR.

Test Plan:
- Reset, MAX_CHARS=16, then sweep all pixels -> busy_out=1 for exactly 16 cycles after rst_in goes high; afterwards pixel_out=0 everywhere and valid_out = valid_in delayed 3 cycles.
- Write slot 0 = code 0 (H); origin (100,50); shift 0; scan row vcount=53 -> pixel_out=1 at hcount 100..104 (3 cycles late); 0 at 99 and 105..107.
- Same slot with shift 1 -> the lit row for glyph row 3 sits at vcount 56..57, hcount 100..109; vcount 66 (dy>>1=8) -> 0.
- Write slot 2 = code 255, and a write with char_we=1 during CLEAR -> slot 2 renders blank; the CLEAR-time write is absent after CLEAR.
- Slot 1 = E with blink=1, BLINK_FRAMES=2; issue 4 frame ticks -> E visible in frames 0-1, hidden in 2-3, visible again in 4; unblinked slot 0 is always visible.
- Write slot 0 = T on the exact cycle S2 reads slot 0 -> that pixel uses the old glyph H; the next pixel in cell 0 uses T. Reassert rst_in mid-frame -> pixel_out=0 next cycle and busy_out=1 again.
